ahbl_sram_slave_if: RTL and testbench
=====================================

Name: ahbl_sram_slave_if

Overview:
AHB-Lite slave front end for the on-chip SRAM path. It sits directly upstream of the SRAM control interface and converts pipelined AHB-Lite address/data phases into single-cycle ahbsram_req pulses with held address, size and write data. It waits for the sramahb_ack handshake, returns read data, and inserts AHB wait states. It also checks the address range and transfer size.

Parameters:
MEM_DEPTH, 512, SRAM depth in 32-bit words; legal byte range is 0 to MEM_DEPTH*4-1.
MEM_AWIDTH, 19, width of ahbsram_addr, as a byte address.

Ports:
HCLK  in  1  clock
HRESETN  in  1  reset, asynchronous assert, active-low
HSEL  in  1  slave select
HADDR  in  32  AHB byte address
HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word
HWDATA  in  32  write data, valid in the data phase
HREADYIN  in  1  bus ready
HREADYOUT  out  1  slave ready, registered
HRESP  out  1  0 = OKAY, 1 = ERROR, registered
HRDATA  out  32  read data, registered
ahbsram_req  out  1  one-cycle request pulse
ahbsram_write  out  1  request direction
ahbsram_size  out  3  latched HSIZE
ahbsram_addr  out  MEM_AWIDTH  latched HADDR[MEM_AWIDTH-1:0]
ahbsram_wdata  out  32  write data to the SRAM controller
ahbsram_wdata_usram  out  32  same value as ahbsram_wdata
sramahb_ack  in  1  completion pulse, arrives 1 cycle after req
sramahb_rdata  in  32  read data, valid 1 cycle after ack
BUSY  in  1  SRAM busy; a request is not issued while BUSY=1

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, ahbsram_req=0, ahbsram_write=0, ahbsram_size=0, ahbsram_addr=0, wdata=0. State returns to IDLE. A reset mid-transfer abandons the transfer; no ack is awaited.
- Transfer acceptance: a transfer is accepted when HSEL & HREADYIN & HTRANS[1] are all high. On acceptance, HADDR, HWRITE and HSIZE are latched.
- IDLE/BUSY transfers (HTRANS[1]=0) and unselected cycles get a zero-wait OKAY response.
- Legality: an access is illegal if HADDR >= MEM_DEPTH*4 or HSIZE > 2.
- State machine states: IDLE, REQ, WAIT_ACK, RD_CAP, DONE, ERR1, ERR2.
- IDLE: on a legal accept go to REQ; on an illegal accept go to ERR1. HREADYOUT=1.
- REQ (data phase): HREADYOUT=0.
  - If BUSY=1, stay in REQ with req=0.
  - Otherwise drive ahbsram_req=1 for exactly one cycle. For writes, register HWDATA into ahbsram_wdata on that cycle, and combinationally pass HWDATA through in that cycle so the controller sees it with the request. Go to WAIT_ACK.
- WAIT_ACK: hold addr, size, write and wdata stable. On sramahb_ack: writes go to DONE, reads go to RD_CAP. If no ack arrives, stay; there is no timeout.
- RD_CAP: HRDATA <= sramahb_rdata; go to DONE.
- DONE: HREADYOUT=1, HRESP=0 for one cycle. In this cycle a new accept is sampled:
  - legal accept goes to REQ;
  - illegal accept goes to ERR1;
  - no accept goes to IDLE.
- Latency, with the address phase at cycle T and no BUSY:
  - write: req at T+1, ack at T+2, HREADYOUT=1 at T+3 (2 wait states);
  - read: req at T+1, ack at T+2, HRDATA and HREADYOUT=1 at T+4 (3 wait states).
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. After ERR2, sample a new accept exactly as in DONE. No ahbsram_req is ever issued for an illegal access.
- HRDATA holds its last value outside read completions.
- Simultaneous events: an ack arriving while in REQ or IDLE is ignored.
- ahbsram_req never re-asserts before the ack of the previous request.

Optional Feature:
AHBL_SRAM_ERR_RESP_EN.
- Defined: illegal accesses receive the two-cycle ERROR response (ERR1/ERR2).
- Undefined: illegal accesses complete as a zero-wait OKAY with no SRAM request. Writes are dropped and reads return HRDATA=0. The ERR states are not built.

Test Plan:
- Word write of 0xDEADBEEF to 0x10, then read of 0x10: req=1 with ahbsram_addr=0x10, size=2, wdata=0xDEADBEEF; HREADYOUT low for 2 cycles on the write and 3 cycles on the read; the read returns HRDATA=0xDEADBEEF, HRESP=0.
- Byte write of 0xAB at 0x13 (HSIZE=0): ahbsram_size=0, ahbsram_addr=0x13, exactly one req pulse, OKAY.
- BUSY held high for 4 cycles during REQ: no req while BUSY=1; req fires the first cycle after BUSY falls; total wait states = 2+4.
- Back-to-back NONSEQ write then read, with the read address phase in the DONE cycle: the second req is issued the cycle after DONE; no idle gap.
- Read at HADDR=MEM_DEPTH*4 (0x800) with the macro defined: no req; HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1. With the macro undefined: zero-wait OKAY, HRDATA=0.
- HRESETN asserted while in WAIT_ACK: outputs immediately reset to their reset values; a following write after reset behaves normally.

Source files
------------

// File: rtl/ahbl_sram_slave_if.sv
// ahbl_sram_slave_if
// AHB-Lite slave front end for the on-chip SRAM path. It accepts AHB-Lite
// transfers and issues one-cycle ahbsram_req pulses while holding the address,
// size, direction and write data. It waits for sramahb_ack, returns read data
// and stretches the data phase with wait states. An illegal access (address
// beyond MEM_DEPTH words, or HSIZE > 2) never reaches the SRAM.
//
// Build option: AHBL_SRAM_ERR_RESP_EN
//   defined   - illegal accesses get the two-cycle ERROR response (ERR1/ERR2).
//   undefined - illegal accesses complete as a zero-wait OKAY. Writes are
//               dropped and reads return zero.
//
// Ports:
//   HCLK, HRESETN            clock, async active-low reset
//   HSEL..HREADYIN           AHB-Lite slave inputs
//   HREADYOUT, HRESP, HRDATA AHB-Lite slave response (registered)
//   ahbsram_req              one-cycle request pulse (same cycle as BUSY low)
//   ahbsram_write/size/addr  request attributes, held until the next accept
//   ahbsram_wdata(_usram)    write data; HWDATA passes through on the req cycle
//   sramahb_ack              completion pulse, one cycle after req
//   sramahb_rdata            read data, one cycle after ack
//   BUSY                     SRAM busy; holds off the request
module ahbl_sram_slave_if #(
  parameter int unsigned MEM_DEPTH  = 512,
  parameter int unsigned MEM_AWIDTH = 19
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  ahbsram_req,
  output logic                  ahbsram_write,
  output logic [2:0]            ahbsram_size,
  output logic [MEM_AWIDTH-1:0] ahbsram_addr,
  output logic [31:0]           ahbsram_wdata,
  output logic [31:0]           ahbsram_wdata_usram,
  input  logic                  sramahb_ack,
  input  logic [31:0]           sramahb_rdata,
  input  logic                  BUSY
);

  localparam int unsigned MEM_BYTES = MEM_DEPTH * 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_ACK = 3'd2,
    RD_CAP   = 3'd3,
    DONE     = 3'd4
`ifdef AHBL_SRAM_ERR_RESP_EN
    ,
    ERR1     = 3'd5,
    ERR2     = 3'd6
`endif
  } state_t;

  state_t      state, next_state;
  logic        accept;
  logic        legal;
  logic        sample;
  logic        ready_nxt;
  logic        resp_nxt;
  logic [31:0] wdata_q;
  logic        unused;

  // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
  assign unused = HTRANS[0];

  assign accept = HSEL & HREADYIN & HTRANS[1];
  assign legal  = (HADDR < 32'(MEM_BYTES)) && (HSIZE <= 3'd2);

  // The controller must see the write data in the same cycle as the request.
  assign ahbsram_wdata       = (ahbsram_req && ahbsram_write) ? HWDATA : wdata_q;
  assign ahbsram_wdata_usram = ahbsram_wdata;

  // Next state, request pulse and next response.
  always_comb begin
    next_state  = state;
    sample      = 1'b0;
    ahbsram_req = 1'b0;
    ready_nxt   = 1'b0;
    resp_nxt    = 1'b0;
    case (state)
      IDLE, DONE: sample = 1'b1;
      REQ: begin
        if (!BUSY) begin
          ahbsram_req = 1'b1;
          next_state  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sramahb_ack) next_state = ahbsram_write ? DONE : RD_CAP;
      end
      RD_CAP: next_state = DONE;
`ifdef AHBL_SRAM_ERR_RESP_EN
      ERR1: next_state = ERR2;
      ERR2: sample = 1'b1;
`endif
      default: next_state = IDLE;
    endcase
    // Cycles that end a data phase also take the next address phase.
    if (sample) begin
      if (!accept)    next_state = IDLE;
      else if (legal) next_state = REQ;
      else begin
`ifdef AHBL_SRAM_ERR_RESP_EN
        next_state = ERR1;
`else
        next_state = IDLE;
`endif
      end
    end
    ready_nxt = (next_state == IDLE) || (next_state == DONE);
`ifdef AHBL_SRAM_ERR_RESP_EN
    ready_nxt = ready_nxt || (next_state == ERR2);
    resp_nxt  = (next_state == ERR1) || (next_state == ERR2);
`endif
  end

  // State, registered AHB response and held request attributes.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state         <= IDLE;
      HREADYOUT     <= 1'b1;
      HRESP         <= 1'b0;
      HRDATA        <= '0;
      ahbsram_write <= 1'b0;
      ahbsram_size  <= '0;
      ahbsram_addr  <= '0;
      wdata_q       <= '0;
    end else begin
      state     <= next_state;
      HREADYOUT <= ready_nxt;
      HRESP     <= resp_nxt;
      if (sample && accept) begin
        ahbsram_write <= HWRITE;
        ahbsram_size  <= HSIZE;
        ahbsram_addr  <= HADDR[MEM_AWIDTH-1:0];
      end
      if (ahbsram_req && ahbsram_write) wdata_q <= HWDATA;
      if (state == RD_CAP) HRDATA <= sramahb_rdata;
`ifndef AHBL_SRAM_ERR_RESP_EN
      // A dropped illegal read still has to return a defined value.
      if (sample && accept && !legal && !HWRITE) HRDATA <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_ahbl_sram_slave_if.sv
// Bench for ahbl_sram_slave_if: an AHB-Lite pipelined driver, an SRAM
// responder that acks one cycle after each request, and a scoreboard of
// expected SRAM requests popped as the DUT issues them.
module tb_ahbl_sram_slave_if;

  localparam int unsigned MEM_DEPTH  = 512;
  localparam int unsigned MEM_AWIDTH = 19;

`ifdef AHBL_SRAM_ERR_RESP_EN
  localparam int   ILL_WAITS = 1;
  localparam logic ILL_RESP  = 1'b1;
`else
  localparam int   ILL_WAITS = 0;
  localparam logic ILL_RESP  = 1'b0;
`endif

  logic                  HCLK = 1'b0;
  logic                  HRESETN;
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [31:0]           HWDATA;
  logic                  HREADYIN;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [31:0]           HRDATA;
  logic                  ahbsram_req;
  logic                  ahbsram_write;
  logic [2:0]            ahbsram_size;
  logic [MEM_AWIDTH-1:0] ahbsram_addr;
  logic [31:0]           ahbsram_wdata;
  logic [31:0]           ahbsram_wdata_usram;
  logic                  sramahb_ack;
  logic [31:0]           sramahb_rdata;
  logic                  BUSY;

  assign HREADYIN = HREADYOUT;

  ahbl_sram_slave_if #(.MEM_DEPTH(MEM_DEPTH), .MEM_AWIDTH(MEM_AWIDTH)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .ahbsram_req(ahbsram_req), .ahbsram_write(ahbsram_write),
    .ahbsram_size(ahbsram_size), .ahbsram_addr(ahbsram_addr),
    .ahbsram_wdata(ahbsram_wdata), .ahbsram_wdata_usram(ahbsram_wdata_usram),
    .sramahb_ack(sramahb_ack), .sramahb_rdata(sramahb_rdata), .BUSY(BUSY)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          busy;
  } xfer_t;

  typedef struct {
    logic [MEM_AWIDTH-1:0] addr;
    logic                  write;
    logic [2:0]            size;
    logic [31:0]           wdata;
  } req_t;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic        resp;
    logic        err_wait;
    int          acyc;
    int          dcyc;
  } res_t;

  xfer_t       pend_q[$];
  req_t        exp_req_q[$];
  res_t        res_q[$];
  int          req_cyc_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          ack_enable = 1'b1;
  logic [31:0] mem [0:MEM_DEPTH-1];

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // SRAM responder and request scoreboard.
  initial begin
    req_t        e;
    int unsigned wi;
    int unsigned lane;
    logic [31:0] rd;
    for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = '0;
    sramahb_ack   = 1'b0;
    sramahb_rdata = '0;
    forever begin
      @(negedge HCLK);
      if (HRESETN === 1'b1 && ahbsram_req === 1'b1) begin
        vectors++;
        if (exp_req_q.size() == 0) begin
          $display("FAIL unexpected_req: got req addr=%h at cycle %0d want no req", ahbsram_addr, cyc);
          miscompares++;
        end else begin
          e = exp_req_q.pop_front();
          if (ahbsram_addr !== e.addr || ahbsram_size !== e.size || ahbsram_write !== e.write ||
              (e.write && (ahbsram_wdata !== e.wdata || ahbsram_wdata_usram !== e.wdata))) begin
            $display("FAIL req_fields: got addr=%h size=%0d write=%b wdata=%h usram=%h want addr=%h size=%0d write=%b wdata=%h",
                     ahbsram_addr, ahbsram_size, ahbsram_write, ahbsram_wdata, ahbsram_wdata_usram,
                     e.addr, e.size, e.write, e.wdata);
            miscompares++;
          end
        end
        req_cyc_q.push_back(cyc);
        if (ack_enable) begin
          wi = int'(ahbsram_addr[MEM_AWIDTH-1:2]);
          rd = '0;
          if (wi < MEM_DEPTH) begin
            if (ahbsram_write) begin
              case (ahbsram_size)
                3'd0: begin
                  lane = 8 * int'(ahbsram_addr[1:0]);
                  mem[wi][lane +: 8] = ahbsram_wdata[lane +: 8];
                end
                3'd1: begin
                  lane = 16 * int'(ahbsram_addr[1]);
                  mem[wi][lane +: 16] = ahbsram_wdata[lane +: 16];
                end
                default: mem[wi] = ahbsram_wdata;
              endcase
            end
            rd = mem[wi];
          end
          @(posedge HCLK); #1;
          sramahb_ack = 1'b1;
          @(posedge HCLK); #1;
          sramahb_ack   = 1'b0;
          sramahb_rdata = rd;
        end
      end
    end
  end

  task automatic drive_addr(input bit have, input xfer_t x);
    if (have) begin
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = x.addr; HWRITE = x.write; HSIZE = x.size;
    end else begin
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = '0;
    end
  endtask

  task automatic add(input logic [31:0] addr, input logic write, input logic [2:0] size,
                     input logic [31:0] wdata, input int busy, input bit exp_req);
    xfer_t x;
    req_t  e;
    x.addr = addr; x.write = write; x.size = size; x.wdata = wdata; x.busy = busy;
    pend_q.push_back(x);
    if (exp_req) begin
      e.addr = addr[MEM_AWIDTH-1:0]; e.write = write; e.size = size; e.wdata = wdata;
      exp_req_q.push_back(e);
    end
  endtask

  // Pipelined AHB master: runs every queued transfer, records each data phase.
  task automatic run_pipe();
    xfer_t cur, nxt;
    res_t  r;
    bit    have_cur, have_nxt, rdy, err_w;
    int    waits, busy_left, acyc_cur, guard;
    have_cur = 1'b0; err_w = 1'b0; waits = 0; busy_left = 0; acyc_cur = 0; guard = 0;
    @(posedge HCLK); #1;
    have_nxt = (pend_q.size() != 0);
    if (have_nxt) nxt = pend_q.pop_front();
    drive_addr(have_nxt, nxt);
    while (have_cur || have_nxt) begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      if (have_cur) begin
        if (!rdy) begin
          waits++;
          if (HRESP) err_w = 1'b1;
        end else begin
          r.waits = waits; r.rdata = HRDATA; r.resp = HRESP; r.err_wait = err_w;
          r.acyc = acyc_cur; r.dcyc = cyc;
          res_q.push_back(r);
        end
      end
      @(posedge HCLK); #1;
      if (rdy) begin
        have_cur  = have_nxt;
        cur       = nxt;
        acyc_cur  = cyc - 1;
        waits     = 0;
        err_w     = 1'b0;
        busy_left = have_cur ? cur.busy : 0;
        HWDATA    = have_cur ? cur.wdata : 32'h0;
        have_nxt  = (pend_q.size() != 0);
        if (have_nxt) nxt = pend_q.pop_front();
        drive_addr(have_nxt, nxt);
      end else if (busy_left > 0) begin
        busy_left--;
      end
      BUSY = (busy_left > 0);
      guard++;
      if (guard > 100) begin
        vectors++; miscompares++;
        $display("FAIL pipe_timeout: got HREADYOUT=%b after %0d cycles want completion", HREADYOUT, guard);
        have_cur = 1'b0; have_nxt = 1'b0; BUSY = 1'b0;
        drive_addr(1'b0, nxt);
        pend_q.delete();
      end
    end
  endtask

  task automatic test_reset();
    HRESETN = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    vectors++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0 || ahbsram_req !== 1'b0 ||
        ahbsram_write !== 1'b0 || ahbsram_size !== 3'd0 || ahbsram_addr !== {MEM_AWIDTH{1'b0}} ||
        ahbsram_wdata !== 32'h0 || ahbsram_wdata_usram !== 32'h0) begin
      $display("FAIL reset_values: got rdy=%b resp=%b rdata=%h req=%b wr=%b size=%0d addr=%h wdata=%h want 1 0 0 0 0 0 0 0",
               HREADYOUT, HRESP, HRDATA, ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata);
      miscompares++;
    end
    HRESETN = 1'b1;
  endtask

  task automatic test_write_read();
    res_t r;
    int   rc;
    add(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 0, 1'b1);
    run_pipe();
    add(32'h10, 1'b0, 3'd2, 32'h0, 0, 1'b1);
    run_pipe();
    vectors++;
    if (res_q.size() != 2 || req_cyc_q.size() != 2) begin
      $display("FAIL wr_rd_count: got %0d results %0d reqs want 2 2", res_q.size(), req_cyc_q.size());
      miscompares++;
    end else begin
      r = res_q.pop_front(); rc = req_cyc_q.pop_front();
      vectors++;
      if (r.waits !== 2 || r.resp !== 1'b0) begin
        $display("FAIL wr_waits: got waits=%0d resp=%b want 2 0", r.waits, r.resp); miscompares++;
      end
      vectors++;
      if (rc !== r.acyc + 1) begin
        $display("FAIL wr_req_cycle: got %0d want %0d", rc, r.acyc + 1); miscompares++;
      end
      r = res_q.pop_front(); rc = req_cyc_q.pop_front();
      vectors++;
      if (r.waits !== 3 || r.resp !== 1'b0 || r.rdata !== 32'hDEADBEEF) begin
        $display("FAIL rd_word: got waits=%0d resp=%b rdata=%h want 3 0 deadbeef", r.waits, r.resp, r.rdata);
        miscompares++;
      end
      vectors++;
      if (rc !== r.acyc + 1) begin
        $display("FAIL rd_req_cycle: got %0d want %0d", rc, r.acyc + 1); miscompares++;
      end
    end
    vectors++;
    if (exp_req_q.size() != 0) begin
      $display("FAIL wr_rd_missing_req: got %0d pending want 0", exp_req_q.size()); miscompares++;
    end
    res_q.delete(); req_cyc_q.delete(); exp_req_q.delete();
  endtask

  task automatic test_byte_write();
    res_t r;
    add(32'h13, 1'b1, 3'd0, 32'hAB000000, 0, 1'b1);
    run_pipe();
    vectors++;
    if (res_q.size() != 1 || req_cyc_q.size() != 1) begin
      $display("FAIL byte_count: got %0d results %0d reqs want 1 1", res_q.size(), req_cyc_q.size());
      miscompares++;
    end else begin
      r = res_q.pop_front();
      vectors++;
      if (r.waits !== 2 || r.resp !== 1'b0 || r.rdata !== 32'hDEADBEEF) begin
        $display("FAIL byte_resp: got waits=%0d resp=%b hrdata=%h want 2 0 deadbeef", r.waits, r.resp, r.rdata);
        miscompares++;
      end
    end
    res_q.delete(); req_cyc_q.delete();
    add(32'h10, 1'b0, 3'd2, 32'h0, 0, 1'b1);
    run_pipe();
    vectors++;
    if (res_q.size() != 1) begin
      $display("FAIL byte_readback_count: got %0d want 1", res_q.size()); miscompares++;
    end else begin
      r = res_q.pop_front();
      vectors++;
      if (r.rdata !== 32'hABADBEEF) begin
        $display("FAIL byte_readback: got %h want abadbeef", r.rdata); miscompares++;
      end
    end
    vectors++;
    if (exp_req_q.size() != 0) begin
      $display("FAIL byte_missing_req: got %0d pending want 0", exp_req_q.size()); miscompares++;
    end
    res_q.delete(); req_cyc_q.delete(); exp_req_q.delete();
  endtask

  task automatic test_busy();
    res_t r;
    int   rc;
    add(32'h20, 1'b1, 3'd2, 32'h12345678, 4, 1'b1);
    run_pipe();
    vectors++;
    if (res_q.size() != 1 || req_cyc_q.size() != 1) begin
      $display("FAIL busy_count: got %0d results %0d reqs want 1 1", res_q.size(), req_cyc_q.size());
      miscompares++;
    end else begin
      r = res_q.pop_front(); rc = req_cyc_q.pop_front();
      vectors++;
      if (r.waits !== 6) begin
        $display("FAIL busy_waits: got %0d want 6", r.waits); miscompares++;
      end
      vectors++;
      if (rc !== r.acyc + 5) begin
        $display("FAIL busy_req_cycle: got %0d want %0d", rc, r.acyc + 5); miscompares++;
      end
    end
    res_q.delete(); req_cyc_q.delete(); exp_req_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t w, r;
    int   rcw, rcr;
    add(32'h40, 1'b1, 3'd2, 32'h55AA55AA, 0, 1'b1);
    add(32'h40, 1'b0, 3'd2, 32'h0, 0, 1'b1);
    run_pipe();
    vectors++;
    if (res_q.size() != 2 || req_cyc_q.size() != 2) begin
      $display("FAIL b2b_count: got %0d results %0d reqs want 2 2", res_q.size(), req_cyc_q.size());
      miscompares++;
    end else begin
      w = res_q.pop_front(); r = res_q.pop_front();
      rcw = req_cyc_q.pop_front(); rcr = req_cyc_q.pop_front();
      vectors++;
      if (w.waits !== 2 || rcw !== w.acyc + 1) begin
        $display("FAIL b2b_write: got waits=%0d req_cycle=%0d want 2 %0d", w.waits, rcw, w.acyc + 1);
        miscompares++;
      end
      vectors++;
      if (r.acyc !== w.dcyc || rcr !== w.dcyc + 1) begin
        $display("FAIL b2b_gap: got addr_cycle=%0d req_cycle=%0d want %0d %0d", r.acyc, rcr, w.dcyc, w.dcyc + 1);
        miscompares++;
      end
      vectors++;
      if (r.waits !== 3 || r.rdata !== 32'h55AA55AA || r.resp !== 1'b0) begin
        $display("FAIL b2b_read: got waits=%0d rdata=%h resp=%b want 3 55aa55aa 0", r.waits, r.rdata, r.resp);
        miscompares++;
      end
    end
    res_q.delete(); req_cyc_q.delete(); exp_req_q.delete();
  endtask

  task automatic test_illegal();
    res_t r;
    add(32'h800, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    add(32'h40, 1'b0, 3'd2, 32'h0, 0, 1'b1);
    add(32'h0, 1'b1, 3'd3, 32'h11111111, 0, 1'b0);
    run_pipe();
    vectors++;
    if (res_q.size() != 3 || req_cyc_q.size() != 1) begin
      $display("FAIL ill_count: got %0d results %0d reqs want 3 1", res_q.size(), req_cyc_q.size());
      miscompares++;
    end else begin
      r = res_q.pop_front();
      vectors++;
      if (r.waits !== ILL_WAITS || r.resp !== ILL_RESP || r.err_wait !== ILL_RESP) begin
        $display("FAIL ill_addr_resp: got waits=%0d resp=%b wait_resp=%b want %0d %b %b",
                 r.waits, r.resp, r.err_wait, ILL_WAITS, ILL_RESP, ILL_RESP);
        miscompares++;
      end
`ifndef AHBL_SRAM_ERR_RESP_EN
      vectors++;
      if (r.rdata !== 32'h0) begin
        $display("FAIL ill_addr_rdata: got %h want 0", r.rdata); miscompares++;
      end
`endif
      r = res_q.pop_front();
      vectors++;
      if (r.waits !== 3 || r.rdata !== 32'h55AA55AA || r.resp !== 1'b0) begin
        $display("FAIL ill_then_read: got waits=%0d rdata=%h resp=%b want 3 55aa55aa 0", r.waits, r.rdata, r.resp);
        miscompares++;
      end
      r = res_q.pop_front();
      vectors++;
      if (r.waits !== ILL_WAITS || r.resp !== ILL_RESP) begin
        $display("FAIL ill_size_resp: got waits=%0d resp=%b want %0d %b", r.waits, r.resp, ILL_WAITS, ILL_RESP);
        miscompares++;
      end
    end
    res_q.delete(); req_cyc_q.delete(); exp_req_q.delete();
  endtask

  task automatic test_reset_mid();
    xfer_t x;
    req_t  e;
    res_t  r;
    ack_enable = 1'b0;
    x.addr = 32'h30; x.write = 1'b1; x.size = 3'd2; x.wdata = 32'h0BADF00D; x.busy = 0;
    e.addr = 19'h30; e.write = 1'b1; e.size = 3'd2; e.wdata = 32'h0BADF00D;
    exp_req_q.push_back(e);
    @(posedge HCLK); #1;
    drive_addr(1'b1, x);
    @(posedge HCLK); #1;
    drive_addr(1'b0, x);
    HWDATA = x.wdata;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    vectors++;
    if (HREADYOUT !== 1'b0 || req_cyc_q.size() != 1) begin
      $display("FAIL mid_wait_ack: got rdy=%b reqs=%0d want 0 1", HREADYOUT, req_cyc_q.size());
      miscompares++;
    end
    #1 HRESETN = 1'b0;
    #1;
    vectors++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0 || ahbsram_req !== 1'b0 ||
        ahbsram_write !== 1'b0 || ahbsram_size !== 3'd0 || ahbsram_addr !== {MEM_AWIDTH{1'b0}} ||
        ahbsram_wdata !== 32'h0) begin
      $display("FAIL mid_reset_values: got rdy=%b resp=%b rdata=%h req=%b wr=%b size=%0d addr=%h wdata=%h want 1 0 0 0 0 0 0 0",
               HREADYOUT, HRESP, HRDATA, ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata);
      miscompares++;
    end
    @(posedge HCLK); #1;
    HRESETN = 1'b1;
    ack_enable = 1'b1;
    req_cyc_q.delete(); exp_req_q.delete();
    add(32'h30, 1'b1, 3'd2, 32'hCAFEF00D, 0, 1'b1);
    add(32'h30, 1'b0, 3'd2, 32'h0, 0, 1'b1);
    run_pipe();
    vectors++;
    if (res_q.size() != 2 || req_cyc_q.size() != 2) begin
      $display("FAIL post_reset_count: got %0d results %0d reqs want 2 2", res_q.size(), req_cyc_q.size());
      miscompares++;
    end else begin
      r = res_q.pop_front();
      vectors++;
      if (r.waits !== 2 || r.resp !== 1'b0) begin
        $display("FAIL post_reset_write: got waits=%0d resp=%b want 2 0", r.waits, r.resp); miscompares++;
      end
      r = res_q.pop_front();
      vectors++;
      if (r.waits !== 3 || r.rdata !== 32'hCAFEF00D) begin
        $display("FAIL post_reset_read: got waits=%0d rdata=%h want 3 cafef00d", r.waits, r.rdata); miscompares++;
      end
    end
    res_q.delete(); req_cyc_q.delete(); exp_req_q.delete();
  endtask

  initial begin
    HRESETN = 1'b0;
    HSEL    = 1'b0;
    HADDR   = '0;
    HTRANS  = 2'b00;
    HWRITE  = 1'b0;
    HSIZE   = '0;
    HWDATA  = '0;
    BUSY    = 1'b0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_busy();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
